// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: configurable word width, clock divide,
// chip-select count and bit order, with per-transfer CPOL/CPHA selection.
module spi_master_param #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned NUM_CS    = 1,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_wr,
    input  logic [2:0]        cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] data_rd,
    output logic              spi_clk,
    output logic [NUM_CS-1:0] cs_n,
    output logic              mosi,
    input  logic              miso
);
    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [DIV_W-1:0]  div_cnt, div_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic              lead, lead_nxt;
    logic              cpol_r, cpol_nxt;
    logic              cpha_r, cpha_nxt;
    logic [DATA_W-1:0] tx_sr, tx_nxt;
    logic [DATA_W-1:0] rx_sr, rx_nxt;
    logic [DATA_W-1:0] data_rd_nxt;
    logic              busy_nxt, done_nxt, spi_clk_nxt, mosi_nxt;
    logic [NUM_CS-1:0] cs_n_nxt;

    logic              div_end;
    logic              cs_valid;
    logic [DATA_W-1:0] tx_shifted;
    logic [DATA_W-1:0] rx_shifted;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    assign div_end    = (div_cnt == DIV_W'(HALF - 1));
    assign cs_valid   = (32'(cs_sel) < NUM_CS);
    assign tx_shifted = MSB_FIRST ? (tx_sr << 1) : (tx_sr >> 1);
    assign rx_shifted = MSB_FIRST ? {rx_sr[DATA_W-2:0], miso} : {miso, rx_sr[DATA_W-1:1]};

    // State and output registers; every output is the registered next value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            lead    <= 1'b0;
            cpol_r  <= 1'b1;
            cpha_r  <= 1'b0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            data_rd <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            spi_clk <= 1'b1;
            mosi    <= 1'b1;
            cs_n    <= '1;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            lead    <= lead_nxt;
            cpol_r  <= cpol_nxt;
            cpha_r  <= cpha_nxt;
            tx_sr   <= tx_nxt;
            rx_sr   <= rx_nxt;
            data_rd <= data_rd_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            spi_clk <= spi_clk_nxt;
            mosi    <= mosi_nxt;
            cs_n    <= cs_n_nxt;
        end
    end

    // Next-state and next-output logic; edges land on half-period boundaries.
    always_comb begin
        state_nxt   = state;
        div_nxt     = '0;
        bit_nxt     = bit_cnt;
        lead_nxt    = lead;
        cpol_nxt    = cpol_r;
        cpha_nxt    = cpha_r;
        tx_nxt      = tx_sr;
        rx_nxt      = rx_sr;
        data_rd_nxt = data_rd;
        busy_nxt    = busy;
        done_nxt    = 1'b0;
        spi_clk_nxt = spi_clk;
        mosi_nxt    = mosi;
        cs_n_nxt    = cs_n;

        if (state != S_IDLE) begin
            div_nxt = div_end ? '0 : div_cnt + DIV_W'(1);
        end

        unique case (state)
            S_IDLE: begin
                spi_clk_nxt = cpol_r;
                mosi_nxt    = 1'b1;
                cs_n_nxt    = '1;
                busy_nxt    = 1'b0;
                if (start && cs_valid) begin
                    state_nxt   = S_SETUP;
                    cpol_nxt    = cpol;
                    cpha_nxt    = cpha;
                    tx_nxt      = data_wr;
                    bit_nxt     = BIT_W'(DATA_W);
                    lead_nxt    = 1'b0;
                    busy_nxt    = 1'b1;
                    spi_clk_nxt = cpol;
                    mosi_nxt    = cpha ? 1'b1 : first_bit(data_wr);
                    cs_n_nxt    = ~(NUM_CS'(1) << cs_sel);
                end
            end
            S_SETUP: begin
                if (div_end) begin
                    state_nxt   = S_XFER;
                    lead_nxt    = 1'b1;
                    spi_clk_nxt = ~cpol_r;
                    if (cpha_r) mosi_nxt = first_bit(tx_sr);
                    else        rx_nxt   = rx_shifted;
                end
            end
            S_XFER: begin
                if (div_end) begin
                    if (lead) begin
                        // Trailing edge: one bit period is complete.
                        lead_nxt    = 1'b0;
                        spi_clk_nxt = cpol_r;
                        if (bit_cnt != '0) bit_nxt = bit_cnt - BIT_W'(1);
                        if (cpha_r) begin
                            rx_nxt = rx_shifted;
                            tx_nxt = tx_shifted;
                        end else if (bit_cnt != BIT_W'(1)) begin
                            tx_nxt   = tx_shifted;
                            mosi_nxt = first_bit(tx_shifted);
                        end
                    end else if (bit_cnt == '0) begin
                        state_nxt = S_HOLD;
                    end else begin
                        lead_nxt    = 1'b1;
                        spi_clk_nxt = ~cpol_r;
                        if (cpha_r) mosi_nxt = first_bit(tx_sr);
                        else        rx_nxt   = rx_shifted;
                    end
                end
            end
            S_HOLD: begin
                if (div_end) begin
                    state_nxt   = S_DONE;
                    cs_n_nxt    = '1;
                    mosi_nxt    = 1'b1;
                    done_nxt    = 1'b1;
                    data_rd_nxt = rx_sr;
                end
            end
            S_DONE: begin
                if (div_end) begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: default, 16-bit LSB-first and 4-CS builds.
`timescale 1ns/1ps
module tb_spi_master_param;
    logic clk = 1'b0;
    logic reset;
    logic cpol, cpha;

    logic       start_a, busy_a, done_a, spi_clk_a, mosi_a, miso_a;
    logic [7:0] data_wr_a, data_rd_a;
    logic [2:0] cs_sel_a;
    logic [0:0] cs_n_a;
    logic       loop_a, miso_drv, drv_en;

    logic        start_b, busy_b, done_b, spi_clk_b, mosi_b;
    logic [15:0] data_wr_b, data_rd_b;
    logic [0:0]  cs_n_b;

    logic       start_c, busy_c, done_c, spi_clk_c, mosi_c;
    logic [7:0] data_wr_c, data_rd_c;
    logic [2:0] cs_sel_c;
    logic [3:0] cs_n_c;

    logic [7:0] pat;
    int         pidx;

    int n_total = 0;
    int n_bad   = 0;

    int         r_busy, r_csl, r_done, r_done_at, r_mchg, r_nlead;
    logic [7:0] r_rd, r_lead;
    logic       r_sclk0;

    int          nb, ncs, nd, nbad, nlead;
    logic        prev;
    logic [15:0] bits, rd;

    spi_master_param u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .data_wr(data_wr_a), .cs_sel(cs_sel_a),
        .cpol(cpol), .cpha(cpha), .busy(busy_a), .done(done_a), .data_rd(data_rd_a),
        .spi_clk(spi_clk_a), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso_a)
    );

    spi_master_param #(.DATA_W(16), .CLK_DIV(8), .NUM_CS(1), .MSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .data_wr(data_wr_b), .cs_sel(3'd0),
        .cpol(cpol), .cpha(cpha), .busy(busy_b), .done(done_b), .data_rd(data_rd_b),
        .spi_clk(spi_clk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(mosi_b)
    );

    spi_master_param #(.NUM_CS(4)) u_dut_c (
        .clk(clk), .reset(reset), .start(start_c), .data_wr(data_wr_c), .cs_sel(cs_sel_c),
        .cpol(cpol), .cpha(cpha), .busy(busy_c), .done(done_c), .data_rd(data_rd_c),
        .spi_clk(spi_clk_c), .cs_n(cs_n_c), .mosi(mosi_c), .miso(mosi_c)
    );

    always #5 clk = ~clk;

    assign miso_a = loop_a ? mosi_a : miso_drv;

    // Slave model for mode 3: present the next pattern bit on each falling spi_clk.
    always @(negedge spi_clk_a) begin
        if (drv_en && pidx < 8) begin
            miso_drv = pat[7-pidx];
            pidx++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transfer on instance A; optional extra start pulse at busy sample mid_at.
    task automatic xfer_a(input logic [7:0] wr, input logic pol, input logic pha, input int mid_at);
        logic psclk, pmosi, pcs;
        r_busy = 0; r_csl = 0; r_done = 0; r_done_at = -1; r_mchg = 0; r_nlead = 0;
        r_rd = '0; r_lead = '0; r_sclk0 = 1'bx;
        @(negedge clk);
        data_wr_a = wr; cpol = pol; cpha = pha; cs_sel_a = 3'd0; start_a = 1'b1;
        psclk = pol; pmosi = 1'b1; pcs = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start_a = (c == mid_at);
            if (c == mid_at) begin
                data_wr_a = ~wr;
                cpha      = ~pha;
            end
            if (!busy_a) break;
            r_busy++;
            if (cs_n_a == 1'b0) r_csl++;
            if (done_a) begin
                r_done++;
                r_rd      = data_rd_a;
                r_done_at = c;
            end
            if (c == 0) r_sclk0 = spi_clk_a;
            if (psclk == pol && spi_clk_a != pol) begin
                r_lead = {r_lead[6:0], mosi_a};
                r_nlead++;
            end
            if (!pcs && !cs_n_a[0] && mosi_a != pmosi && !(psclk && !spi_clk_a)) r_mchg++;
            psclk = spi_clk_a; pmosi = mosi_a; pcs = cs_n_a[0];
        end
        start_a = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cpol = 1'b0; cpha = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        data_wr_a = '0; data_wr_b = '0; data_wr_c = 8'h5A;
        cs_sel_a = '0; cs_sel_c = '0;
        loop_a = 1'b1; miso_drv = 1'b0; drv_en = 1'b0; pidx = 0; pat = 8'h3C;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_cs_n", cs_n_a, 1);
        check("rst_sclk", spi_clk_a, 1);
        check("rst_mosi", mosi_a, 1);
        check("rst_data_rd", data_rd_a, 0);

        // Mode 0 loopback
        xfer_a(8'hA5, 1'b0, 1'b0, -1);
        check("m0_busy_len", r_busy, 38);
        check("m0_cs_len", r_csl, 36);
        check("m0_done_cnt", r_done, 1);
        check("m0_done_at", r_done_at, 36);
        check("m0_data_rd", r_rd, 8'hA5);
        check("m0_mosi_bits", r_lead, 8'hA5);
        check("m0_lead_cnt", r_nlead, 8);

        // Mode 3 with the slave pattern
        loop_a = 1'b0; drv_en = 1'b1; pidx = 0;
        xfer_a(8'h96, 1'b1, 1'b1, -1);
        drv_en = 1'b0; loop_a = 1'b1;
        check("m3_data_rd", r_rd, 8'h3C);
        check("m3_mosi_bits", r_lead, 8'h96);
        check("m3_mosi_edge", r_mchg, 0);
        check("m3_sclk_setup", r_sclk0, 1);
        check("m3_sclk_idle", spi_clk_a, 1);
        check("m3_busy_len", r_busy, 38);

        // Start pulse during busy is ignored
        xfer_a(8'h5A, 1'b0, 1'b0, 9);
        check("mid_done_cnt", r_done, 1);
        check("mid_data_rd", r_rd, 8'h5A);
        check("mid_busy_len", r_busy, 38);
        nb = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy_a) nb++;
        end
        check("mid_no_queue", nb, 0);

        // Reset during XFER bit 4
        @(negedge clk);
        data_wr_a = 8'hC3; cpol = 1'b0; cpha = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (18) @(negedge clk);
        check("abort_active", {busy_a, cs_n_a}, 2'b10);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_cs_n", cs_n_a, 1);
        check("abort_sclk", spi_clk_a, 1);
        check("abort_mosi", mosi_a, 1);
        check("abort_busy", busy_a, 0);
        check("abort_data_rd", data_rd_a, 0);
        nd = 0; nb = 0;
        repeat (50) begin
            @(negedge clk);
            if (done_a) nd++;
            if (busy_a) nb++;
        end
        check("abort_no_done", nd, 0);
        check("abort_idle", nb, 0);
        xfer_a(8'h81, 1'b0, 1'b0, -1);
        check("post_data_rd", r_rd, 8'h81);
        check("post_busy_len", r_busy, 38);
        check("post_done_cnt", r_done, 1);

        // 16-bit, CLK_DIV=8, LSB first, loopback
        cpol = 1'b0; cpha = 1'b0;
        @(negedge clk);
        data_wr_b = 16'h1234; start_b = 1'b1;
        nb = 0; ncs = 0; nd = 0; nlead = 0; bits = '0; rd = '0; prev = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (!busy_b) break;
            nb++;
            if (cs_n_b == 1'b0) ncs++;
            if (done_b) begin
                nd++;
                rd = data_rd_b;
            end
            if (!prev && spi_clk_b) begin
                if (nlead < 16) bits[nlead] = mosi_b;
                nlead++;
            end
            prev = spi_clk_b;
        end
        start_b = 1'b0;
        check("w16_busy_len", nb, 140);
        check("w16_cs_len", ncs, 136);
        check("w16_mosi_bits", bits, 16'h1234);
        check("w16_lead_cnt", nlead, 16);
        check("w16_data_rd", rd, 16'h1234);
        check("w16_done_cnt", nd, 1);

        // Four chip selects: valid index 2, then out-of-range index 5
        @(negedge clk);
        cs_sel_c = 3'd2; start_c = 1'b1;
        nb = 0; ncs = 0; nd = 0; nbad = 0; rd = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start_c = 1'b0;
            if (!busy_c) break;
            nb++;
            if (cs_n_c == 4'b1011) ncs++;
            else if (cs_n_c != 4'hF) nbad++;
            if (done_c) begin
                nd++;
                rd = 16'(data_rd_c);
            end
        end
        start_c = 1'b0;
        check("cs2_busy_len", nb, 38);
        check("cs2_cs_len", ncs, 36);
        check("cs2_other_cs", nbad, 0);
        check("cs2_done_cnt", nd, 1);
        check("cs2_data_rd", rd, 16'h005A);
        check("cs2_sclk_idle", spi_clk_c, 0);
        @(negedge clk);
        cs_sel_c = 3'd5; start_c = 1'b1;
        nb = 0; nd = 0; nbad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 2) start_c = 1'b0;
            if (busy_c) nb++;
            if (done_c) nd++;
            if (cs_n_c != 4'hF) nbad++;
        end
        check("cs5_busy", nb, 0);
        check("cs5_done", nd, 0);
        check("cs5_cs_n", nbad, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
